// File: rtl/crc_frame_tx.sv
// crc_frame_tx: frames one 32-bit payload word as SOF, 4 payload bytes and a
// 16-bit CRC obtained from an external engine, streamed over valid/ready.
// Optional macro CRC_FRAME_TIMEOUT_EN: abandon the frame with an err pulse when
// the CRC engine does not answer within TIMEOUT cycles.
//
// state    | meaning
// IDLE     | waiting for wr; payload latched on acceptance
// CRC_REQ  | one-cycle crc_start pulse to the engine
// CRC_WAIT | waiting for crc_done (optionally bounded by TIMEOUT)
// SEND     | streaming the 7 frame bytes selected by idx
// FIN      | one-cycle done pulse, back to IDLE
module crc_frame_tx #(
  parameter logic [7:0] SOF     = 8'h7E,
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        crc_start,
  output logic [31:0] crc_data,
  input  logic [16:0] crc_in,
  input  logic        crc_done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CRC_REQ, CRC_WAIT, SEND, FIN} state_t;

  state_t      state;
  logic [31:0] payload;
  logic [15:0] crc;
  logic [2:0]  idx;

  // Bit 16 of the engine result carries no frame content.
  logic crc_msb_unused;
  assign crc_msb_unused = crc_in[16];

`ifdef CRC_FRAME_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy     = (state != IDLE);
  assign crc_data = payload;

  // Sequencer: state, payload/CRC capture, byte index and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      payload   <= 32'h0;
      crc       <= 16'h0;
      idx       <= 3'd0;
      crc_start <= 1'b0;
      tx_valid  <= 1'b0;
      done      <= 1'b0;
`ifdef CRC_FRAME_TIMEOUT_EN
      wait_cnt  <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      crc_start <= 1'b0;
      done      <= 1'b0;
`ifdef CRC_FRAME_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wr) begin
            payload   <= data_in;
            crc_start <= 1'b1;
            state     <= CRC_REQ;
          end
        end
        CRC_REQ: begin
`ifdef CRC_FRAME_TIMEOUT_EN
          wait_cnt <= 8'd0;
`endif
          state <= CRC_WAIT;
        end
        CRC_WAIT: begin
          // crc_done wins over a timeout expiring in the same cycle
          if (crc_done) begin
            crc      <= crc_in[15:0];
            idx      <= 3'd0;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
`ifdef CRC_FRAME_TIMEOUT_EN
          else if (wait_cnt == (TIMEOUT - 8'd1)) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == 3'd6) begin
              tx_valid <= 1'b0;
              done     <= 1'b1;
              idx      <= 3'd0;
              state    <= FIN;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte mux; held constant by idx while the downstream stalls.
  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:    tx_data = SOF;
        3'd1:    tx_data = payload[31:24];
        3'd2:    tx_data = payload[23:16];
        3'd3:    tx_data = payload[15:8];
        3'd4:    tx_data = payload[7:0];
        3'd5:    tx_data = crc[15:8];
        3'd6:    tx_data = crc[7:0];
        default: tx_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Bench for crc_frame_tx: directed and randomized frames checked against a
// byte-list model of the frame; timeout behaviour follows CRC_FRAME_TIMEOUT_EN.
module tb_crc_frame_tx;

  localparam logic [7:0] SOF = 8'h7E;
  localparam logic [7:0] TO  = 8'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        busy;
  logic        crc_start;
  logic [31:0] crc_data;
  logic [16:0] crc_in = 17'h0;
  logic        crc_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        done;
  logic        err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  crc_frame_tx #(.SOF(SOF), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .busy(busy),
    .crc_start(crc_start), .crc_data(crc_data), .crc_in(crc_in),
    .crc_done(crc_done), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One whole frame: request, CRC answer after dly cycles, byte stream, done.
  task automatic drive_frame(input logic [31:0] d, input logic [15:0] c, input int dly,
                             input int bp_idx, input int bp_len, input bit rnd,
                             input bit poke, input string tag);
    logic [7:0] exp_q[$];
    int n, cyc, stall;
    bit rdy;
    exp_q = {SOF, d[31:24], d[23:16], d[15:8], d[7:0], c[15:8], c[7:0]};
    wr = 1'b1; data_in = d;
    step();
    wr = 1'b0; data_in = $urandom;
    chk_cnt++; if (crc_start !== 1'b1) $display("FAIL %s crc_start_pulse got=%b exp=1", tag, crc_start); else pass_cnt++;
    chk_cnt++; if (crc_data !== d) $display("FAIL %s crc_data got=%h exp=%h", tag, crc_data, d); else pass_cnt++;
    step();
    chk_cnt++; if (crc_start !== 1'b0) $display("FAIL %s crc_start_len got=%b exp=0", tag, crc_start); else pass_cnt++;
    repeat (dly - 1) step();
    chk_cnt++; if (crc_data !== d) $display("FAIL %s crc_data_wait got=%h exp=%h", tag, crc_data, d); else pass_cnt++;
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL %s valid_in_wait got=%b exp=0", tag, tx_valid); else pass_cnt++;
    crc_done = 1'b1; crc_in = {1'($urandom_range(0, 1)), c};
    step();
    crc_done = 1'b0; crc_in = 17'($urandom);
    chk_cnt++; if (tx_valid !== 1'b1) $display("FAIL %s first_valid got=%b exp=1", tag, tx_valid); else pass_cnt++;
    n = 0; cyc = 0; stall = 0;
    while (n < 7 && cyc < 300) begin
      if (bp_len > 0 && n == bp_idx && stall < bp_len) begin rdy = 1'b0; stall++; end
      else if (rnd) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      tx_ready = rdy;
      wr = poke && (n == 3);
      if (poke) data_in = 32'hAAAAAAAA;
      chk_cnt++; if (tx_valid !== 1'b1) $display("FAIL %s valid[%0d] got=%b exp=1", tag, n, tx_valid); else pass_cnt++;
      chk_cnt++; if (tx_data !== exp_q[n]) $display("FAIL %s byte[%0d] got=%h exp=%h", tag, n, tx_data, exp_q[n]); else pass_cnt++;
      chk_cnt++; if (crc_start !== 1'b0) $display("FAIL %s crc_start_send got=%b exp=0", tag, crc_start); else pass_cnt++;
      if (rdy) n++;
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    wr = poke;
    chk_cnt++; if (n !== 7) $display("FAIL %s transfers got=%0d exp=7", tag, n); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1) $display("FAIL %s done_pulse got=%b exp=1", tag, done); else pass_cnt++;
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL %s valid_in_fin got=%b exp=0", tag, tx_valid); else pass_cnt++;
    if (!rnd) begin
      chk_cnt++; if (cyc !== 7 + bp_len) $display("FAIL %s latency got=%0d exp=%0d", tag, cyc, 7 + bp_len); else pass_cnt++;
    end
    step();
    wr = 1'b0;
    chk_cnt++; if (done !== 1'b0) $display("FAIL %s done_len got=%b exp=0", tag, done); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL %s busy_after got=%b exp=0", tag, busy); else pass_cnt++;
    chk_cnt++; if (crc_start !== 1'b0) $display("FAIL %s fin_wr_ignored got=%b exp=0", tag, crc_start); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    chk_cnt++; if ({busy, crc_start, tx_valid, done, err} !== 5'b0) $display("FAIL reset_ctrl got=%b exp=00000", {busy, crc_start, tx_valid, done, err}); else pass_cnt++;
    chk_cnt++; if ({tx_data, crc_data} !== 40'h0) $display("FAIL reset_data got=%h exp=0", {tx_data, crc_data}); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    drive_frame(32'h12345678, 16'hABCD, 5, 0, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    drive_frame(32'h12345678, 16'hABCD, 5, 2, 3, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_busy_ignore();
    drive_frame(32'hCAFEF00D, 16'h1357, 3, 0, 0, 1'b0, 1'b1, "busy_ignore");
  endtask

  task automatic test_done_at_limit();
    drive_frame(32'h0BADBEEF, 16'h2468, int'(TO), 0, 0, 1'b0, 1'b0, "done_at_limit");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++)
      drive_frame($urandom, 16'($urandom), $urandom_range(1, int'(TO)), $urandom_range(0, 6),
                  $urandom_range(0, 4), k[0], k[1], "random");
  endtask

  task automatic test_timeout();
    int k;
    bit seen_valid;
    wr = 1'b1; data_in = $urandom;
    step();
    wr = 1'b0;
    step();
`ifdef CRC_FRAME_TIMEOUT_EN
    k = 0; seen_valid = 1'b0;
    while (err !== 1'b1 && k < 50) begin
      step();
      k++;
      if (tx_valid === 1'b1) seen_valid = 1'b1;
    end
    chk_cnt++; if (k !== int'(TO)) $display("FAIL timeout_cycles got=%0d exp=%0d", k, TO); else pass_cnt++;
    chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL timeout_no_byte got=%b exp=0", seen_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL timeout_busy got=%b exp=0", busy); else pass_cnt++;
    step();
    chk_cnt++; if (err !== 1'b0) $display("FAIL timeout_err_len got=%b exp=0", err); else pass_cnt++;
`else
    k = 0; seen_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (busy !== 1'b1 || err !== 1'b0) k++;
      if (tx_valid === 1'b1) seen_valid = 1'b1;
    end
    chk_cnt++; if (k !== 0) $display("FAIL wait_forever bad_cycles got=%0d exp=0", k); else pass_cnt++;
    chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL wait_forever_no_byte got=%b exp=0", seen_valid); else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
`endif
  endtask

  task automatic test_mid_reset();
    bit seen;
    wr = 1'b1; data_in = 32'hDEADBEEF;
    step();
    wr = 1'b0;
    repeat (3) step();
    crc_done = 1'b1; crc_in = 17'h05A5A;
    step();
    crc_done = 1'b0;
    tx_ready = 1'b1;
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if ({busy, crc_start, tx_valid, done, err} !== 5'b0) $display("FAIL midreset_ctrl got=%b exp=00000", {busy, crc_start, tx_valid, done, err}); else pass_cnt++;
    chk_cnt++; if ({tx_data, crc_data} !== 40'h0) $display("FAIL midreset_data got=%h exp=0", {tx_data, crc_data}); else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      step();
      if (tx_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL midreset_no_resume got=%b exp=0", seen); else pass_cnt++;
    drive_frame($urandom, 16'($urandom), 2, 0, 0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_ignore();
    test_done_at_limit();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
